shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the 8-bit ALU shift/rotate path. Accepts one shift request
//  (operand, amount, op) over a valid/ready handshake, applies it STEP bits per cycle
//  through a one-step shift/rotate unit, and returns the result over a valid/ready
//  handshake. Sits between the ALU decode and the register writeback mux; it replaces the
//  single-cycle 16-way select, trading latency for area.
// PARAMETERS
//  STEP   1   bits shifted per SHIFT cycle; legal 1, 2, 4 (elaboration error otherwise)
// PORTS
//  CLK        in   1  clock, rising edge
//  RESET      in   1  asynchronous, active-high reset
//  in_valid   in   1  request valid
//  in_ready   out  1  controller can accept a request (high only in IDLE)
//  in_data    in   8  operand
//  in_amount  in   4  shift amount 0..15
//  in_op      in   2  00 SLL, 01 SRL, 10 SRA, 11 ROR
//  flush      in   1  abort the current operation, return to IDLE
//  out_valid  out  1  result valid (high only in DONE)
//  out_ready  in   1  consumer accepts result
//  out_data   out  8  result
//  busy       out  1  high in SHIFT or DONE
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-op): state=IDLE, in_ready=1, out_valid=0,
//    out_data=8'h00, busy=0, internal remaining count=0. Output state is cleared the same
//    cycle RESET asserts and holds until the first CLK edge after RESET deasserts.
//  - States IDLE, SHIFT, DONE.
//    IDLE : in_ready=1. On in_valid at an edge, capture data/op. Also load
//           rem = effective amount. Go to SHIFT if rem!=0, else DONE.
//    SHIFT: each edge, shift the register by k = min(STEP, rem), rem -= k. When rem
//           reaches 0 on that edge, go to DONE.
//    DONE : out_valid=1, out_data=register. On out_ready at an edge, go to IDLE.
//           out_data is stable while out_valid=1 and out_ready=0.
//  - Effective amount:
//    ROR -> in_amount[2:0], so amount 8..15 wraps to 0..7.
//    SLL/SRL/SRA -> amount, saturated to 8 when in_amount>=8.
//  - Per-step fill:
//    SLL fills 0 at LSB. SRL fills 0 at MSB. SRA replicates captured bit 7.
//    ROR moves bit 0 to bit 7.
//    Final values: SLL/SRL with amount>=8 give 8'h00; SRA with amount>=8 gives
//    {8{data[7]}}; ROR by 0 returns data unchanged.
//  - Latency, from the accept edge to the first cycle out_valid=1: ceil(eff/STEP)+1 cycles.
//    Amount 0 takes 1 cycle. Throughput is one request per latency+1 cycles when
//    out_ready is held high. No new accept happens in the cycle DONE exits.
//  - flush: when sampled high at an edge in SHIFT or DONE, go to IDLE and drop the result;
//    out_valid is low the next cycle. flush has priority over out_ready and over step
//    completion. flush in IDLE is ignored, and in_valid is still accepted that edge.
//  - in_valid while busy is not accepted; the requester holds it (standard valid/ready).
// STRUCTURE
//  - Package shift_seq_pkg: typedef enum logic[1:0] shift_op_t {OP_SLL, OP_SRL, OP_SRA,
//    OP_ROR}; typedef enum logic[1:0] seq_state_t {S_IDLE, S_SHIFT, S_DONE};
//    localparam MAX_LOG_SHIFT=8.
//  - Sub-module shift_step_unit, combinational: inputs data[7:0], op, k[2:0] (0..STEP);
//    output data shifted/rotated by k. It is instantiated once. The FSM, the rem counter
//    and the data register live in shift_sequencer.
// TESTING
//  1 Reset mid-SHIFT: start SLL 8'h01 amount 7, assert RESET in cycle 3 -> out_valid=0,
//    out_data=8'h00, in_ready=1 immediately. A new request afterwards completes normally.
//  2 STEP=1, SRA 8'h90 amount 3 -> out_data=8'hF2, out_valid first high 4 cycles after the
//    accept. SRL 8'h90 amount 3 -> 8'h12.
//  3 ROR 8'hA5 amount 9 -> 8'hD2, same as amount 1. ROR 8'h3C amount 8 -> 8'h3C after
//    1 cycle.
//  4 Saturation: SLL 8'hFF amount 15 -> 8'h00. SRA 8'h80 amount 12 -> 8'hFF. STEP=4 latency
//    is 3 cycles.
//  5 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0,
//    and a second in_valid is not accepted until one cycle after the out_ready handshake.
//  6 flush in SHIFT, together with out_ready -> no out_valid pulse, in_ready=1 next cycle;
//    the following request SRL 8'h80 amount 7 -> 8'h01.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the multi-cycle shift/rotate sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } seq_state_t;

    // Largest meaningful logical/arithmetic shift of an 8-bit operand
    localparam int unsigned MAX_LOG_SHIFT = 8;

    // Rotates wrap modulo 8; shifts saturate at a full-width shift
    function automatic logic [3:0] effective_amount(shift_op_t op, logic [3:0] amount);
        if (op == OP_ROR) begin
            return {1'b0, amount[2:0]};
        end else if (amount >= 4'(MAX_LOG_SHIFT)) begin
            return 4'(MAX_LOG_SHIFT);
        end else begin
            return amount;
        end
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// One-step shift/rotate unit: moves the operand by k bit positions (k <= 4).
module shift_step_unit
    import shift_seq_pkg::*;
(
    input  logic [7:0] data,
    input  shift_op_t  op,
    input  logic [2:0] k,
    output logic [7:0] result
);

    // Select the shifted/rotated operand for the requested operation
    always_comb begin
        result = data;
        case (op)
            OP_SLL:  result = data << k;
            OP_SRL:  result = data >> k;
            OP_SRA:  result = 8'($signed(data) >>> k);
            OP_ROR:  result = 8'({data, data} >> k);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: accepts a request, shifts STEP bits
// per cycle through a single step unit, then holds the result until taken.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [3:0] in_amount,
    input  logic [1:0] in_op,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
            $error("shift_sequencer: STEP must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [3:0] STEP_W = 4'(STEP);

    seq_state_t state;
    shift_op_t  op_r;
    logic [7:0] data_r;
    logic [3:0] rem;
    logic [3:0] eff;
    logic [2:0] k;
    logic [7:0] stepped;

    assign eff      = effective_amount(shift_op_t'(in_op), in_amount);
    assign out_data = data_r;

    // Step size for this cycle: a full STEP, or whatever is left
    always_comb begin
        k = rem[2:0];
        if (rem > STEP_W) begin
            k = STEP_W[2:0];
        end
    end

    shift_step_unit u_step (
        .data   (data_r),
        .op     (op_r),
        .k      (k),
        .result (stepped)
    );

    // Control FSM with registered handshake/status outputs and the data path
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            op_r      <= OP_SLL;
            data_r    <= '0;
            rem       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data_r   <= in_data;
                        op_r     <= shift_op_t'(in_op);
                        rem      <= eff;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (eff != '0) begin
                            state <= S_SHIFT;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        rem      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        data_r <= stepped;
                        rem    <= rem - {1'b0, k};
                        if (rem == {1'b0, k}) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: STEP=1 and STEP=4 instances share stimulus and
// are each compared every cycle against a transaction-level model.
module tb_shift_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [3:0] in_amount = 4'h0;
    logic [1:0] in_op = 2'b00;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready1, out_valid1, busy1;
    logic [7:0] out_data1;
    logic       in_ready4, out_valid4, busy4;
    logic [7:0] out_data4;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    shift_sequencer #(.STEP(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_amount(in_amount), .in_op(in_op), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
    );

    shift_sequencer #(.STEP(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_amount(in_amount), .in_op(in_op), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Result computed directly with integer arithmetic
    function automatic logic [7:0] ref_result(logic [1:0] op, logic [7:0] d, logic [3:0] amt);
        int n;
        int v;
        n = (amt >= 4'd8) ? 8 : int'(amt);
        case (op)
            2'b00: v = int'(d) << n;
            2'b01: v = int'(d) >> n;
            2'b10: begin
                v = int'(d) - (d[7] ? 256 : 0);
                v = v >>> n;
            end
            default: begin
                n = int'(amt) % 8;
                v = (int'(d) >> n) | (int'(d) << (8 - n));
            end
        endcase
        return 8'(v & 255);
    endfunction

    // Cycles from the accept edge until out_valid is first seen
    function automatic int ref_latency(logic [1:0] op, logic [3:0] amt, int step);
        int eff;
        eff = (op == 2'b11) ? int'(amt) % 8 : ((amt >= 4'd8) ? 8 : int'(amt));
        return (eff + step - 1) / step + 1;
    endfunction

    typedef struct {
        bit         pending;
        int         wait_cnt;
        logic [7:0] result;
        bit         zero_data;
    } model_t;

    localparam model_t MODEL_RESET = '{pending: 1'b0, wait_cnt: 0, result: 8'h00, zero_data: 1'b1};

    model_t m1 = MODEL_RESET;
    model_t m4 = MODEL_RESET;

    function automatic model_t model_step(model_t m, int step);
        model_t n;
        n = m;
        if (m.pending) begin
            if (flush) n.pending = 1'b0;
            else if (m.wait_cnt == 0) begin
                if (out_ready) n.pending = 1'b0;
            end else n.wait_cnt = m.wait_cnt - 1;
        end else if (in_valid) begin
            n.pending   = 1'b1;
            n.result    = ref_result(in_op, in_data, in_amount);
            n.wait_cnt  = ref_latency(in_op, in_amount, step) - 1;
            n.zero_data = 1'b0;
        end
        return n;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m1 <= MODEL_RESET;
            m4 <= MODEL_RESET;
        end else begin
            m1 <= model_step(m1, 1);
            m4 <= model_step(m4, 4);
        end
    end

    task automatic check_dut(input string nm, input model_t m, input logic rdy,
                             input logic vld, input logic bsy, input logic [7:0] dat);
        logic exp_vld;
        exp_vld = m.pending && (m.wait_cnt == 0);
        chk({nm, ".in_ready"}, 8'(rdy), 8'(!m.pending));
        chk({nm, ".busy"}, 8'(bsy), 8'(m.pending));
        chk({nm, ".out_valid"}, 8'(vld), 8'(exp_vld));
        if (exp_vld) chk({nm, ".out_data"}, dat, m.result);
        else if (m.zero_data) chk({nm, ".out_data_rst"}, dat, 8'h00);
    endtask

    // Cycle-by-cycle comparison against the model for both instances
    always @(negedge CLK) begin
        check_dut("d1", m1, in_ready1, out_valid1, busy1, out_data1);
        check_dut("d4", m4, in_ready4, out_valid4, busy4, out_data4);
    end

    task automatic run_req(input logic [1:0] op, input logic [7:0] d, input logic [3:0] amt,
                           output int lat1, output int lat4,
                           output logic [7:0] d1, output logic [7:0] d4);
        lat1 = 0; lat4 = 0; d1 = 8'h00; d4 = 8'h00;
        @(negedge CLK);
        in_valid = 1'b1; in_op = op; in_data = d; in_amount = amt;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge CLK);
            if (out_valid1 && lat1 == 0) begin lat1 = c; d1 = out_data1; end
            if (out_valid4 && lat4 == 0) begin lat4 = c; d4 = out_data4; end
            if (lat1 != 0 && lat4 != 0) break;
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic wait_valid1(input string nm);
        int c;
        c = 0;
        while (!out_valid1 && c < 40) begin
            @(negedge CLK);
            c++;
        end
        if (!out_valid1) chk_int({nm, ".timeout"}, 0, 1);
    endtask

    int         l1, l4;
    logic [7:0] r1, r4;

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst.out_valid", 8'(out_valid1), 8'h00);
        chk("rst.out_data", out_data1, 8'h00);
        chk("rst.in_ready", 8'(in_ready1), 8'h01);
        chk("rst.busy", 8'(busy1), 8'h00);
        RESET = 1'b0;

        // Hand-computed values that pin the reference model
        chk("ref.sra90_3", ref_result(2'b10, 8'h90, 4'd3), 8'hF2);
        chk("ref.srl90_3", ref_result(2'b01, 8'h90, 4'd3), 8'h12);
        chk("ref.rorA5_9", ref_result(2'b11, 8'hA5, 4'd9), 8'hD2);
        chk("ref.sllFF_15", ref_result(2'b00, 8'hFF, 4'd15), 8'h00);
        chk("ref.sra80_12", ref_result(2'b10, 8'h80, 4'd12), 8'hFF);
        chk_int("ref.lat_s4_sat", ref_latency(2'b00, 4'd15, 4), 3);

        // Arithmetic vs logical right shift, STEP=1 latency
        run_req(2'b10, 8'h90, 4'd3, l1, l4, r1, r4);
        chk("sra.d1", r1, 8'hF2); chk_int("sra.lat1", l1, 4);
        chk("sra.d4", r4, 8'hF2); chk_int("sra.lat4", l4, 2);
        run_req(2'b01, 8'h90, 4'd3, l1, l4, r1, r4);
        chk("srl.d1", r1, 8'h12); chk("srl.d4", r4, 8'h12);

        // Rotate wrap-around
        run_req(2'b11, 8'hA5, 4'd9, l1, l4, r1, r4);
        chk("ror9.d1", r1, 8'hD2); chk_int("ror9.lat1", l1, 2);
        run_req(2'b11, 8'hA5, 4'd1, l1, l4, r1, r4);
        chk("ror1.d1", r1, 8'hD2);
        run_req(2'b11, 8'h3C, 4'd8, l1, l4, r1, r4);
        chk("ror8.d1", r1, 8'h3C); chk_int("ror8.lat1", l1, 1); chk_int("ror8.lat4", l4, 1);

        // Saturated shifts
        run_req(2'b00, 8'hFF, 4'd15, l1, l4, r1, r4);
        chk("sll15.d1", r1, 8'h00); chk_int("sll15.lat1", l1, 9);
        chk("sll15.d4", r4, 8'h00); chk_int("sll15.lat4", l4, 3);
        run_req(2'b10, 8'h80, 4'd12, l1, l4, r1, r4);
        chk("sra12.d1", r1, 8'hFF); chk("sra12.d4", r4, 8'hFF);

        // Asynchronous reset in the middle of a shift
        @(negedge CLK);
        in_valid = 1'b1; in_op = 2'b00; in_data = 8'h01; in_amount = 4'd7;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        chk("amid.out_valid", 8'(out_valid1), 8'h00);
        chk("amid.out_data", out_data1, 8'h00);
        chk("amid.in_ready", 8'(in_ready1), 8'h01);
        chk("amid.busy", 8'(busy1), 8'h00);
        chk("amid.d4_out_data", out_data4, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        run_req(2'b00, 8'h01, 4'd7, l1, l4, r1, r4);
        chk("post_rst.d1", r1, 8'h80); chk_int("post_rst.lat1", l1, 8);
        chk("post_rst.d4", r4, 8'h80); chk_int("post_rst.lat4", l4, 3);

        // Backpressure: result held, second request blocked until after handshake
        @(negedge CLK);
        in_valid = 1'b1; in_op = 2'b01; in_data = 8'hA5; in_amount = 4'd2;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        wait_valid1("bp");
        in_valid = 1'b1; in_op = 2'b00; in_data = 8'h0F; in_amount = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp.hold_data", out_data1, 8'h29);
            chk("bp.in_ready", 8'(in_ready1), 8'h00);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("bp.exit_busy", 8'(busy1), 8'h00);
        chk("bp.exit_ready", 8'(in_ready1), 8'h01);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("bp.accept_busy", 8'(busy1), 8'h01);
        wait_valid1("bp2");
        chk("bp.second", out_data1, 8'h1E);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;

        // flush during SHIFT wins over out_ready
        @(negedge CLK);
        in_valid = 1'b1; in_op = 2'b00; in_data = 8'h55; in_amount = 4'd7;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        flush = 1'b0; out_ready = 1'b0;
        chk("flush.in_ready", 8'(in_ready1), 8'h01);
        chk("flush.out_valid", 8'(out_valid1), 8'h00);
        chk("flush.d4_out_valid", 8'(out_valid4), 8'h00);
        run_req(2'b01, 8'h80, 4'd7, l1, l4, r1, r4);
        chk("flush_next.d1", r1, 8'h01); chk("flush_next.d4", r4, 8'h01);

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_amount = 4'($urandom_range(0, 15));
            in_op     = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
